fifo_stream_reader: RTL
=======================

Name: fifo_stream_reader

Overview:
Reader end of the synchronous FIFO. Pops words via the FIFO's rd/dout/empty port, absorbs the FIFO's one-cycle read latency, and presents them as a valid/ready stream with a burst-boundary marker. It sits between the FIFO and any downstream consumer, sustaining one word per cycle with no combinational path from m_ready to fifo_rd.

Parameters:
DATA_WIDTH, 8, width of FIFO dout and m_data
BURST_LEN, 4, words per burst; m_last marks every BURST_LEN-th word (legal range 1..256)
CNT_WIDTH, 16, width of the word_cnt statistics counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
fifo_rd  out  1  pop request to FIFO; dout valid the following cycle
fifo_dout  in  DATA_WIDTH  FIFO read data, valid one cycle after fifo_rd
fifo_empty  in  1  FIFO empty flag
m_valid  out  1  stream data valid
m_ready  in  1  consumer ready
m_data  out  DATA_WIDTH  stream data
m_last  out  1  final word of current burst
word_cnt  out  CNT_WIDTH  total words accepted (m_valid && m_ready), wraps

Behaviour:
- Reset (rst_n=0, async): fifo_rd=0, m_valid=0, m_data=0, m_last=0, word_cnt=0. Buffer occupancy, in-flight flag and beat counter cleared.
- Internal 3-entry in-order buffer (SKID_DEPTH=3). occ = entries held (0..3). inflight = 1 if fifo_rd was asserted in the previous cycle.
- fifo_rd = !fifo_empty && (occ + inflight) < 3. Depends only on fifo_empty and registers. Never asserted while fifo_empty=1.
- Capture: when inflight=1, fifo_dout is written into the buffer tail that cycle.
- Latency: first word appears on m_valid two cycles after fifo_empty deasserts with an empty buffer. Cycle N: rd issued. N+1: data captured. N+2: m_valid=1.
- m_valid = (occ != 0). m_data = buffer head, registered output.
- Handshake: a word transfers when m_valid && m_ready.
- While m_valid=1 and m_ready=0, m_data and m_last hold stable.
- m_valid never drops without a handshake.
- Throughput: with FIFO non-empty and m_ready held high, one transfer per cycle in steady state.
- Simultaneous capture and pop in the same cycle: occ unchanged and ordering preserved.
- Overflow is impossible by construction. Worst case is occ=2, inflight=1, no pop, giving occ=3, at which point fifo_rd=0.
- Beat counter: 0..BURST_LEN-1. Increments on each handshake and wraps to 0 after BURST_LEN-1.
- m_last = m_valid && (beat == BURST_LEN-1). With BURST_LEN=1, m_last = m_valid.
- word_cnt: increments on each handshake and wraps modulo 2^CNT_WIDTH. No saturation.
- FIFO goes empty mid-stream: buffer drains normally, m_valid falls after the last entry transfers, and the beat counter retains its position. Bursts span idle gaps.
- Reset mid-operation: buffered and in-flight words are discarded. The FIFO shares rst_n and empties too. The beat counter restarts at 0.

Decomposition:
- Shared package fifo_stream_pkg holds:
  - localparam SKID_DEPTH=3;
  - localparam PTR_W=$clog2(SKID_DEPTH);
  - typedef logic [PTR_W:0] occ_t.
- Sub-module stream_skid_buf: 3-entry register FIFO with push/pop/occ, registered head output, parameterised on DATA_WIDTH.
- Top level holds fifo_rd issue logic, the inflight flag, the beat counter and word_cnt.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with fifo_empty=1, then release -> all outputs 0. fifo_rd stays 0 for 20 cycles.
- Single word: FIFO writes 0xA5, m_ready=1 -> fifo_rd pulses once, m_valid=1 for exactly one cycle with m_data=0xA5, word_cnt=1.
- Streaming: FIFO preloaded 0x00..0x0F, m_ready=1 constant -> 16 consecutive beats with no gaps after the 2-cycle start latency, data in order, m_last on 0x03/0x07/0x0B/0x0F, word_cnt=16.
- Backpressure: preloaded 0x10..0x17, m_ready toggled 1,0,0,1,... -> fifo_rd stops once occ+inflight=3, no word lost or duplicated, m_data stable during stalls, output sequence 0x10..0x17.
- Gap across burst: write 0x20,0x21, let FIFO drain, wait 5 cycles, write 0x22,0x23 -> m_last only on 0x23. The beat counter is preserved across the idle gap.
- Reset mid-stream: assert rst_n low while occ=2 and inflight=1 -> m_valid=0 immediately (async), word_cnt=0. After refill with 0x30..0x33, m_last asserts on 0x33.

Source files
------------

// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FIFO stream reader slice.
//   SKID_DEPTH : number of words the reader buffers between FIFO and stream
//   PTR_W      : index width for the buffer entries
//   occ_t      : occupancy type, wide enough to hold 0..SKID_DEPTH
package fifo_stream_pkg;

    localparam int unsigned SKID_DEPTH = 3;
    localparam int unsigned PTR_W      = $clog2(SKID_DEPTH);

    typedef logic [PTR_W:0] occ_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Small in-order register FIFO holding words read from the upstream FIFO.
// The head entry is a register and drives the stream data directly.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din at the tail this cycle
//   pop        : remove the head entry (ignored when empty)
//   head       : current head word (registered)
//   occ        : number of entries held, 0..SKID_DEPTH
module stream_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output occ_t                  occ
);

    logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
    logic                  pop_ok;
    occ_t                  wr_pos;
    occ_t                  occ_nxt;

    assign pop_ok = pop && (occ != '0);
    assign head   = mem[0];

    // Entries shift toward index 0 on a pop, so the tail slot moves down by
    // one when a push and a pop coincide.
    assign wr_pos = pop_ok ? (occ - occ_t'(1)) : occ;

    always_comb begin
        occ_nxt = occ;
        case ({push, pop_ok})
            2'b10:   occ_nxt = occ + occ_t'(1);
            2'b01:   occ_nxt = occ - occ_t'(1);
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            occ <= '0;
        end else begin
            if (pop_ok) begin
                for (int unsigned i = 0; i < SKID_DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            // Later assignment wins, so the pushed word overrides the shift.
            if (push) begin
                mem[wr_pos[PTR_W-1:0]] <= din;
            end
            occ <= occ_nxt;
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Reader end of the synchronous FIFO. Issues pops, absorbs the FIFO's
// one-cycle read latency and presents words as a valid/ready stream with a
// burst-boundary marker and a running transfer count.
//   clk, rst_n  : clock, asynchronous active-low reset
//   fifo_rd     : pop request to the FIFO (data returns next cycle)
//   fifo_dout   : FIFO read data
//   fifo_empty  : FIFO empty flag
//   m_valid     : stream word valid
//   m_ready     : consumer ready
//   m_data      : stream word
//   m_last      : last word of the current burst of BURST_LEN words
//   word_cnt    : total words transferred, wraps
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    logic       inflight;
    occ_t       occ;
    occ_t       pending;
    logic       xfer;
    logic [7:0] beat;

    stream_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .din   (fifo_dout),
        .pop   (xfer),
        .head  (m_data),
        .occ   (occ)
    );

    // Reserve a buffer slot for every word already requested so the buffer
    // can never overflow; m_ready is deliberately not part of this term.
    assign pending = occ + occ_t'(inflight);
    assign fifo_rd = rst_n && !fifo_empty && (pending < occ_t'(SKID_DEPTH));

    assign m_valid = (occ != '0);
    assign xfer    = m_valid && m_ready;
    assign m_last  = m_valid && (beat == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            beat     <= '0;
            word_cnt <= '0;
        end else begin
            inflight <= fifo_rd;
            if (xfer) begin
                beat     <= (beat == LAST_BEAT) ? 8'd0 : beat + 8'd1;
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

endmodule
